// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester owner IDs and the arbitration helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Pick the requester to serve: on contention, the one not served last.
  function automatic logic pick_owner(input logic cpu_req,
                                      input logic dbg_req,
                                      input logic last_owner);
    if (cpu_req && dbg_req) begin
      return ~last_owner;
    end else if (cpu_req) begin
      return OWN_CPU;
    end else begin
      return OWN_DBG;
    end
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Transfer timeout counter for the memory port arbiter.
// Used only when MEM_ARB_TIMEOUT_EN is defined. Counts stalled transfer
// cycles; expired flags the cycle on which LIMIT-1 stalls have elapsed.
module arb_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_reg;

  // Clear on transfer entry, count stalled cycles, hold once expired.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (inc && !expired) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for a single memory port.
// Fair alternation on contention, one transfer at a time: IDLE -> XFER -> DONE.
// Optional transfer timeout enabled by the macro MEM_ARB_TIMEOUT_EN; without it
// a transfer waits for mem_rdy indefinitely and err is tied low.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  arb_state_t    state_reg, state_next;
  logic          owner_reg;
  logic          last_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          grant;
  logic          grant_owner;
  logic          timed_out;

  assign grant       = (state_reg == IDLE) && (cpu_req || dbg_req);
  assign grant_owner = pick_owner(cpu_req, dbg_req, last_reg);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;
  logic err_reg;

  arb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant),
    .inc    ((state_reg == XFER) && !mem_rdy),
    .expired(expired)
  );

  assign timed_out = (state_reg == XFER) && !mem_rdy && expired;

  // Remember whether the transfer ended by timeout so err accompanies the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == XFER) begin
      err_reg <= timed_out;
    end
  end

  assign err = (state_reg == DONE) && err_reg;
`else
  localparam int timeout_unused = TIMEOUT_CYC;
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and output decode; memory strobes only while transferring.
  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant) state_next = XFER;
      end
      XFER: begin
        mem_en    = 1'b1;
        mem_we    = we_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        if (mem_rdy || timed_out) state_next = DONE;
      end
      DONE: begin
        cpu_ack    = (owner_reg == OWN_CPU);
        dbg_ack    = (owner_reg == OWN_DBG);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, grant capture, read-data load and fairness pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_CPU;
      last_reg  <= OWN_DBG;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_reg <= grant_owner;
        we_reg    <= (grant_owner == OWN_CPU) ? cpu_we    : dbg_we;
        addr_reg  <= (grant_owner == OWN_CPU) ? cpu_addr  : dbg_addr;
        wdata_reg <= (grant_owner == OWN_CPU) ? cpu_wdata : dbg_wdata;
      end
      if ((state_reg == XFER) && mem_rdy && !we_reg) begin
        rdata_reg <= mem_rdata;
      end
      if (state_reg == DONE) begin
        last_reg <= owner_reg;
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences (alternation, reset mid-transfer, timeout / MEM_ARB_TIMEOUT_EN)
// and a randomized run against a transaction-schedule reference model.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  typedef struct {
    logic          cr;
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    int            dly;
    logic [DW-1:0] mrd;
    logic          own;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at a negedge, DUT idle, reset released, all inputs quiet.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transaction from the table; starts and ends on an idle cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int xfers;
    bit acked;
    int ack_k;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dbg_req = v.dr; dbg_we = v.dw; dbg_addr = v.da; dbg_wdata = v.dd;
    mem_rdy = 1'b1;
    mem_rdata = ~v.mrd;
    xfers = 0;
    acked = 1'b0;
    ack_k = -1;
    for (int k = 1; k <= 40 && !acked; k++) begin
      @(negedge clk);
      if (mem_en) begin
        xfers++;
        chk("vec_mem_we", 32'(mem_we), 32'(v.ewe));
        chk("vec_mem_addr", 32'(mem_addr), 32'(v.eaddr));
        chk("vec_mem_wdata", 32'(mem_wdata), 32'(v.ewd));
        chk("vec_ack_in_xfer", 32'({cpu_ack, dbg_ack}), 32'(0));
        if (xfers == v.dly + 1) begin
          mem_rdy = 1'b1; mem_rdata = v.mrd;
        end else begin
          mem_rdy = 1'b0; mem_rdata = ~v.mrd;
        end
      end else if (cpu_ack || dbg_ack) begin
        acked = 1'b1;
        ack_k = k;
        chk("vec_ack_cycle", 32'(k), 32'(v.dly + 2));
        chk("vec_xfer_len", 32'(xfers), 32'(v.dly + 1));
        chk("vec_cpu_ack", 32'(cpu_ack), 32'(v.own == 1'b0));
        chk("vec_dbg_ack", 32'(dbg_ack), 32'(v.own == 1'b1));
        chk("vec_err", 32'(err), 32'(0));
        chk("vec_rdata", 32'(rdata), 32'(v.erd));
        cpu_req = 1'b0; dbg_req = 1'b0;
        mem_rdy = 1'b1; mem_rdata = ~v.mrd;
      end else begin
        mem_rdy = 1'b1; mem_rdata = ~v.mrd;
      end
    end
    if (!acked) chk("vec_ack_timeout", 32'(0), 32'(1));
    @(negedge clk);
    chk("vec_idle_after", 32'({mem_en, cpu_ack, dbg_ack}), 32'(0));
    chk("vec_rdata_hold", 32'(rdata), 32'(v.erd));
    mem_rdy = 1'b0;
    $display("vec %0d: owner %s we %0d addr %02h ack_cycle %0d rdata %04h",
             idx, v.own ? "DBG" : "CPU", v.ewe, v.eaddr, ack_k, rdata);
  endtask

  // Random-run reference model state (transaction schedule, not FSM states).
  int            xs, xe, ack_at, free_at, own, last;
  int            xfers_t, ack_k_t;
  bit            acked_t, in_x;
  logic          err_at;
  logic [DW-1:0] rd_at;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wd, rdy_data, exp_rd;
  logic          rq[2];
  logic          we_m[2];
  logic [AW-1:0] addr_m[2];
  logic [DW-1:0] wd_m[2];

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    do_reset();

    // Reset state
    chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("rst_dbg_ack", 32'(dbg_ack), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));

    // Directed table; owner column follows the fairness history top to bottom.
    //          cr    cw    ca     cd        dr    dw    da     dd        dly mrd       own   ewe   eaddr  ewd       erd
    tbl[0] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 16'hBEEF, 1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h3F, 16'h1234, 3, 16'hDEAD, 1'b1, 1'b1, 8'h3F, 16'h1234, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 8'h22, 16'h0001, 1'b1, 1'b0, 8'h33, 16'h0002, 1, 16'hA5A5, 1'b0, 1'b0, 8'h22, 16'h0001, 16'hA5A5};
    tbl[3] = '{1'b1, 1'b1, 8'h44, 16'h1111, 1'b1, 1'b1, 8'h55, 16'h2222, 0, 16'h7777, 1'b1, 1'b1, 8'h55, 16'h2222, 16'hA5A5};
    tbl[4] = '{1'b1, 1'b0, 8'h66, 16'h0000, 1'b1, 1'b0, 8'h77, 16'h0000, 2, 16'h0F0F, 1'b0, 1'b0, 8'h66, 16'h0000, 16'h0F0F};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'hFF, 16'hABCD, 0, 16'hFFFF, 1'b1, 1'b0, 8'hFF, 16'hABCD, 16'hFFFF};
    tbl[6] = '{1'b1, 1'b1, 8'h00, 16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000, 1, 16'h1357, 1'b0, 1'b1, 8'h00, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Both requests held: CPU, DBG, CPU with acks three cycles apart.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02;
    mem_rdy = 1'b1; mem_rdata = 16'h0101;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("alt_cpu_ack", 32'(cpu_ack), 32'(k == 2 || k == 8));
      chk("alt_dbg_ack", 32'(dbg_ack), 32'(k == 5));
      if (k == 4) chk("alt_dbg_addr", 32'(mem_addr), 32'(8'h02));
    end
    cpu_req = 1'b0; dbg_req = 1'b0; mem_rdy = 1'b0;
    $display("seq alternation: CPU/DBG/CPU acks expected in cycles 2/5/8");

    // Reset in the second transfer cycle drops the transaction.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 16'h4321;
    mem_rdy = 1'b0;
    @(negedge clk);
    chk("rstx_xfer1", 32'(mem_en), 32'(1));
    @(negedge clk);
    chk("rstx_xfer2", 32'(mem_en), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("rstx_mem_en", 32'(mem_en), 32'(0));
    chk("rstx_acks", 32'({cpu_ack, dbg_ack}), 32'(0));
    chk("rstx_mem_addr", 32'(mem_addr), 32'(0));
    chk("rstx_mem_we", 32'(mem_we), 32'(0));
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h31;
    mem_rdy = 1'b1; mem_rdata = 16'h6666;
    @(negedge clk);
    chk("rstx_regrant_en", 32'(mem_en), 32'(1));
    chk("rstx_regrant_addr", 32'(mem_addr), 32'(8'h21));
    chk("rstx_no_ack", 32'({cpu_ack, dbg_ack}), 32'(0));
    @(negedge clk);
    chk("rstx_cpu_ack", 32'(cpu_ack), 32'(1));
    chk("rstx_dbg_ack", 32'(dbg_ack), 32'(0));
    chk("rstx_rdata", 32'(rdata), 32'(16'h6666));
    cpu_req = 1'b0; dbg_req = 1'b0; mem_rdy = 1'b0;
    $display("seq reset-in-xfer: dropped, CPU regranted first");

    // Stalled memory: timeout with err, or an indefinite wait without the feature.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    mem_rdy = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    @(negedge clk);
    chk("to_pre_ack", 32'(cpu_ack), 32'(1));
    cpu_req = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 8'h06; mem_rdy = 1'b0; mem_rdata = 16'hC3C3;
    xfers_t = 0; acked_t = 1'b0; ack_k_t = -1; err_at = 1'b0; rd_at = '0;
    for (int k = 1; k <= 40 && !acked_t; k++) begin
      @(negedge clk);
      if (mem_en) begin
        xfers_t++;
        chk("to_err_in_xfer", 32'(err), 32'(0));
      end else if (cpu_ack) begin
        acked_t = 1'b1; ack_k_t = k; err_at = err; rd_at = rdata;
        cpu_req = 1'b0;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("to_acked", 32'(acked_t), 32'(1));
    chk("to_xfer_len", 32'(xfers_t), 32'(15));
    chk("to_ack_cycle", 32'(ack_k_t), 32'(16));
    chk("to_err", 32'(err_at), 32'(1));
    chk("to_rdata_kept", 32'(rd_at), 32'(16'h5A5A));
    @(negedge clk);
    chk("to_err_clear", 32'(err), 32'(0));
    $display("seq timeout: ack after %0d stalled cycles, err %0d", xfers_t, err_at);
`else
    chk("noto_acked", 32'(acked_t), 32'(0));
    chk("noto_xfer_len", 32'(xfers_t), 32'(40));
    chk("noto_err", 32'(err), 32'(0));
    $display("seq no-timeout: transfer still pending after %0d cycles", xfers_t);
`endif

    // Randomized traffic against the transaction-schedule model.
    do_reset();
    xs = -10; xe = -10; ack_at = -10; free_at = 0; own = 0; last = 1;
    g_we = 1'b0; g_addr = '0; g_wd = '0; rdy_data = '0; exp_rd = '0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; we_m[i] = 1'b0; addr_m[i] = '0; wd_m[i] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      in_x = (n >= xs) && (n <= xe);
      if (n == ack_at && !g_we) exp_rd = rdy_data;
      chk("rnd_mem_en", 32'(mem_en), 32'(in_x));
      chk("rnd_cpu_ack", 32'(cpu_ack), 32'(n == ack_at && own == 0));
      chk("rnd_dbg_ack", 32'(dbg_ack), 32'(n == ack_at && own == 1));
      chk("rnd_rdata", 32'(rdata), 32'(exp_rd));
      chk("rnd_err", 32'(err), 32'(0));
      if (in_x) begin
        chk("rnd_mem_we", 32'(mem_we), 32'(g_we));
        chk("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
        chk("rnd_mem_wdata", 32'(mem_wdata), 32'(g_wd));
      end
      if (n == ack_at) begin
        $display("rnd txn: owner %s we %0d addr %02h len %0d rdata %04h",
                 own == 0 ? "CPU" : "DBG", g_we, g_addr, xe - xs + 1, rdata);
      end
      // Requesters: owner holds (or may drop mid-transfer) until its ack; others may raise.
      for (int i = 0; i < 2; i++) begin
        if (i == own && n <= ack_at) begin
          if (n == ack_at) rq[i] = 1'b0;
          else if (n <= xe && $urandom_range(0, 7) == 0) rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i]     = 1'b1;
          we_m[i]   = 1'($urandom_range(0, 1));
          addr_m[i] = AW'($urandom);
          wd_m[i]   = DW'($urandom);
        end
      end
      // Arbiter free and someone asking: grant at the closing edge of this cycle.
      if (n >= free_at && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) own = 1 - last;
        else own = rq[0] ? 0 : 1;
        last     = own;
        xs       = n + 1;
        xe       = xs + int'($urandom_range(0, 3));
        ack_at   = xe + 1;
        free_at  = ack_at + 1;
        g_we     = we_m[own];
        g_addr   = addr_m[own];
        g_wd     = wd_m[own];
        rdy_data = DW'($urandom);
      end
      cpu_req = rq[0]; cpu_we = we_m[0]; cpu_addr = addr_m[0]; cpu_wdata = wd_m[0];
      dbg_req = rq[1]; dbg_we = we_m[1]; dbg_addr = addr_m[1]; dbg_wdata = wd_m[1];
      if (in_x) begin
        mem_rdy   = (n == xe);
        mem_rdata = (n == xe) ? rdy_data : DW'($urandom);
      end else begin
        mem_rdy   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
